weight_stream_buffer: RTL and testbench
=======================================

Name: weight_stream_buffer

Overview:
- Writable, parametrised weight store for one conv block. It replaces the fixed-depth, read-only, address-driven weight ROMs.
- Weights are preloaded through a write port, or from an optional init file at elaboration.
- On a start command, streams a burst of words from a base address to the PE array over a valid/ready handshake, with full backpressure support.
- Sits between the controller (start/base/len) and the PE weight input.

Parameters:
- DATA_WIDTH, 32, bits per weight word (packed binary weights).
- DATA_DEPTH, 64, number of words stored.
- ADDR_WIDTH, 6, address bits; requires 2^ADDR_WIDTH >= DATA_DEPTH.
- LEN_WIDTH, 7, burst-length bits (ADDR_WIDTH+1).
- INIT_FILE, "" (empty), $readmemb file loaded at elaboration when non-empty; otherwise contents are undefined until written.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- start  in  1  burst request pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first read address, captured with start
- burst_len  in  LEN_WIDTH  beat count, captured with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at burst completion
- w_valid  out  1  output word valid
- w_ready  in  1  consumer ready
- w_data  out  DATA_WIDTH  weight word
- w_last  out  1  marks final beat of burst

Behaviour:
- Reset (async assert, sync deassert edge): busy=0, done=0, w_valid=0, w_last=0, w_data=0. FSM returns to IDLE; in-flight reads and skid FIFO are discarded. Memory contents are NOT reset. Reset mid-burst aborts the burst with no done pulse.
- Memory: one synchronous read port, one write port, read-first, 1-cycle read latency.
  - Write to the address being read in the same cycle: the read returns old data.
  - Writes are accepted in every state, including during a burst. Overwriting not-yet-read words during a burst is legal and the burst sees the new data.
  - wr_addr >= DATA_DEPTH: write is ignored.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: start=1 captures base_addr/burst_len and sets busy=1 on the next edge.
    - If burst_len==0: go directly to a done pulse with no beats; busy=1 for exactly one cycle concurrent with done.
    - Otherwise go to STREAM.
  - STREAM: issue one read per cycle while (skid FIFO occupancy + reads in flight) < 2. Read address increments modulo DATA_DEPTH, so base_addr+i wraps past DATA_DEPTH-1 to 0. After issuing burst_len reads, go to DRAIN.
  - DRAIN: wait until every issued word has been handshaken (w_valid & w_ready). On the last handshake: done=1 for the following cycle, busy=0 in that same cycle, state to IDLE.
- start is ignored when not in IDLE; no queuing.
- Output path: 2-entry skid FIFO fed by the RAM.
  - w_valid = FIFO non-empty; w_data = FIFO head.
  - w_data and w_last hold stable while w_valid & !w_ready.
  - w_last=1 only on beat burst_len-1.
- Latency: start at edge N gives the first read issued in cycle N+1 and w_valid=1 in cycle N+2. With w_ready held high, sustained throughput is 1 beat/cycle and the burst takes burst_len+2 cycles from start to done.
- Maximum burst_len is DATA_DEPTH; larger values are clamped to DATA_DEPTH.
- The beat counter is LEN_WIDTH bits wide. The address counter is ADDR_WIDTH bits wide with explicit wrap compare at DATA_DEPTH-1; it does not rely on power-of-two depth.

Decomposition:
- Shared package weight_buf_pkg:
  - FSM state enum (IDLE/STREAM/DRAIN).
  - SKID_DEPTH=2 constant.
  - Function for clamped burst length.
- Sub-module weight_sync_ram: parametrised DATA_WIDTH/DATA_DEPTH/ADDR_WIDTH/INIT_FILE, one write port, one read-first synchronous read port with read enable. It is reused by the other block buffers.

Test Plan:
- Preload by writes, word k = k+0xA5000000 for k=0..63. Start base=0, len=4, w_ready=1 -> beats 0xA5000000..0xA5000003 on consecutive cycles, w_last on the 4th, done one cycle after the last handshake, busy low in that cycle.
- Wrap-around: base=62, len=4 -> data words 62,63,0,1 in that order, w_last on word 1.
- Backpressure: len=8, w_ready toggling 1,0,0,1,... -> no beat lost or duplicated, w_data stable while stalled, exactly 8 handshakes, single done.
- len=0 start -> done pulse with busy for 1 cycle, w_valid never asserted. A start issued mid-burst is ignored, with no second done.
- Concurrent write: during a len=16 burst from 0, write 0xDEADBEEF to addr 10 three cycles before it is read -> beat 10 = 0xDEADBEEF. A write to the same address in its read cycle -> old value is returned.
- Async reset asserted mid-burst, with no clock edge -> w_valid/busy/done drop immediately. After release, a new burst from 0 returns the preserved memory contents.

Source files
------------

// File: rtl/weight_buf_pkg.sv
// Shared definitions for the weight stream buffer.
//   state_e          : burst controller states
//   SKID_DEPTH       : entries in the output skid FIFO
//   clamp_burst_len  : limits a requested burst length to the store depth
package weight_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;

    function automatic int unsigned clamp_burst_len(input int unsigned len,
                                                    input int unsigned depth);
        int unsigned res;
        if (len > depth) begin
            res = depth;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/weight_sync_ram.sv
// Simple dual-port weight store: one write port, one synchronous read-first
// read port with read enable and 1-cycle latency. Contents are never reset.
// Ports:
//   clk            : clock
//   wr_en/wr_addr/wr_data : write port; addresses >= DATA_DEPTH are ignored
//   rd_en/rd_addr  : read request
//   rd_data        : read result, valid the cycle after rd_en, held otherwise
module weight_sync_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Memory array: nonblocking read and write give read-first behaviour.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_LIM)) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/weight_stream_buffer.sv
// Writable weight store that streams a burst of words to the PE array.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data: preload/update port, accepted in every state
//   start/base_addr/burst_len : burst request, sampled only when idle
//   busy, done           : burst in progress / one-cycle completion pulse
//   w_valid/w_ready/w_data/w_last : output stream with backpressure
// The RAM output register behaves as a fall-through head in front of a
// 2-entry skid FIFO, so a word is presented the cycle after it is read.
module weight_stream_buffer
    import weight_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  issue_rem_q, issue_rem_d;   // reads still to issue
    logic [LEN_WIDTH-1:0]  beat_rem_q, beat_rem_d;     // handshakes still owed
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q, inflight_d;     // RAM output holds a word
    logic                  inflight_last_q, inflight_last_d;

    logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SKID_DEPTH-1:0]                 skid_last_q, skid_last_d;
    logic                                  skid_rd_ptr_q, skid_rd_ptr_d;
    logic                                  skid_wr_ptr_q, skid_wr_ptr_d;
    logic [1:0]                            skid_cnt_q, skid_cnt_d;

    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  head_from_skid;
    logic                  pop;
    logic                  skid_push;
    logic                  skid_pop;
    logic                  issue;
    logic [2:0]            occ;
    logic [LEN_WIDTH-1:0]  len_clamped;

    weight_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rd_data)
    );

    assign len_clamped = LEN_WIDTH'(clamp_burst_len(32'(burst_len), 32'(DATA_DEPTH)));

    // Output head selection: oldest skid entry first, else the RAM word.
    always_comb begin
        head_from_skid = (skid_cnt_q != 2'd0);
        w_valid        = head_from_skid | inflight_q;
        w_data         = {DATA_WIDTH{1'b0}};
        w_last         = 1'b0;
        if (head_from_skid) begin
            w_data = skid_data_q[skid_rd_ptr_q];
            w_last = skid_last_q[skid_rd_ptr_q];
        end else if (inflight_q) begin
            w_data = ram_rd_data;
            w_last = inflight_last_q;
        end else begin
            w_data = {DATA_WIDTH{1'b0}};
            w_last = 1'b0;
        end
    end

    // Skid FIFO bookkeeping and read-issue throttle.
    always_comb begin
        pop       = w_valid & w_ready;
        skid_pop  = pop & head_from_skid;
        // A RAM word consumed straight from the output register never enters the FIFO.
        skid_push = inflight_q & ~(pop & ~head_from_skid);
        // Words held after this cycle's handshake; keep at most two buffered.
        occ       = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == ST_STREAM) && (issue_rem_q != LEN_ZERO) && (occ < 3'd2);

        skid_data_d   = skid_data_q;
        skid_last_d   = skid_last_q;
        skid_wr_ptr_d = skid_wr_ptr_q;
        skid_rd_ptr_d = skid_rd_ptr_q;
        if (skid_push) begin
            skid_data_d[skid_wr_ptr_q] = ram_rd_data;
            skid_last_d[skid_wr_ptr_q] = inflight_last_q;
            skid_wr_ptr_d              = ~skid_wr_ptr_q;
        end else begin
            skid_wr_ptr_d = skid_wr_ptr_q;
        end
        if (skid_pop) begin
            skid_rd_ptr_d = ~skid_rd_ptr_q;
        end else begin
            skid_rd_ptr_d = skid_rd_ptr_q;
        end
        skid_cnt_d = skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};
    end

    // Burst controller next-state logic.
    always_comb begin
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        issue_rem_d     = issue_rem_q;
        beat_rem_d      = beat_rem_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue & (issue_rem_q == LEN_ONE);

        if (pop) begin
            beat_rem_d = beat_rem_q - LEN_ONE;
        end else begin
            beat_rem_d = beat_rem_q;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    rd_addr_d   = base_addr;
                    issue_rem_d = len_clamped;
                    beat_rem_d  = len_clamped;
                    busy_d      = 1'b1;
                    if (len_clamped == LEN_ZERO) begin
                        // Empty burst: busy and done together for one cycle.
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    // Explicit wrap so non power-of-two depths also work.
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = ADDR_ZERO;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                    end
                    issue_rem_d = issue_rem_q - LEN_ONE;
                    if (issue_rem_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (pop && (beat_rem_q == LEN_ONE)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any burst in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rd_addr_q       <= ADDR_ZERO;
            issue_rem_q     <= LEN_ZERO;
            beat_rem_q      <= LEN_ZERO;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            skid_data_q     <= {(SKID_DEPTH * DATA_WIDTH){1'b0}};
            skid_last_q     <= {SKID_DEPTH{1'b0}};
            skid_rd_ptr_q   <= 1'b0;
            skid_wr_ptr_q   <= 1'b0;
            skid_cnt_q      <= 2'd0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            issue_rem_q     <= issue_rem_d;
            beat_rem_q      <= beat_rem_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            skid_data_q     <= skid_data_d;
            skid_last_q     <= skid_last_d;
            skid_rd_ptr_q   <= skid_rd_ptr_d;
            skid_wr_ptr_q   <= skid_wr_ptr_d;
            skid_cnt_q      <= skid_cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Self-checking bench for weight_stream_buffer. Expected bursts are derived
// from a shadow copy of the store and the stated timing rules.
module tb_weight_stream_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          w_last;

    weight_stream_buffer #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];

    // Observation state, written only by the monitor below.
    int          cyc = 0;
    logic [32:0] got_q [$];
    int          hs_q [$];
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          busy_cnt = 0;
    int          stall_viol = 0;
    int          done_cyc = 0;
    logic        busy_at_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record handshakes, done pulses and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (w_valid) valid_cnt <= valid_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc;
                busy_at_done <= busy;
            end
            if (prev_stall && (w_valid !== 1'b1 || w_data !== prev_data || w_last !== prev_last))
                stall_viol <= stall_viol + 1;
            if (w_valid && w_ready) begin
                got_q.push_back({w_last, w_data});
                hs_q.push_back(cyc);
            end
            prev_stall <= w_valid & ~w_ready;
            prev_data  <= w_data;
            prev_last  <= w_last;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 = ready always high, 1 = ready pattern 1,0,0, 2 = random ready.
    // w*_at: cycle offset after start acceptance at which a write is driven (-1 none).
    // mid_at: cycle offset at which an extra start is pulsed (-1 none).
    task automatic run_burst(input string tag, input int base, input int len, input int mode,
                             input int w1_at, input int w1_addr, input logic [31:0] w1_data,
                             input int w2_at, input int w2_addr, input logic [31:0] w2_data,
                             input int mid_at);
        int n, q0, d0, v0, b0, s0, s_cyc, k, a;
        bit fin;
        logic [31:0] word;
        logic [32:0] exp_q [$];
        n = (len > DEPTH) ? DEPTH : len;
        // Beat i is read in cycle s_cyc+i; a write lands at the end of its cycle.
        for (int i = 0; i < n; i++) begin
            a    = (base + i) % DEPTH;
            word = model_mem[a];
            if (w1_at >= 0 && w1_at < i && w1_addr == a) word = w1_data;
            if (w2_at >= 0 && w2_at < i && w2_addr == a) word = w2_data;
            exp_q.push_back({(i == n - 1), word});
        end
        q0 = got_q.size(); d0 = done_cnt; v0 = valid_cnt; b0 = busy_cnt; s0 = stall_viol;
        start = 1'b1; base_addr = AW'(base); burst_len = LW'(len); w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        k = 0; fin = 1'b0;
        while (!fin && k < 600) begin
            case (mode)
                0:       w_ready = 1'b1;
                1:       w_ready = (k % 3 == 0);
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
            wr_en = 1'b0;
            if (k == w1_at) begin wr_en = 1'b1; wr_addr = AW'(w1_addr); wr_data = w1_data; end
            if (k == w2_at) begin wr_en = 1'b1; wr_addr = AW'(w2_addr); wr_data = w2_data; end
            start = (k == mid_at); base_addr = AW'(5); burst_len = LW'(2);
            @(posedge clk); #1;
            fin = (done_cnt != d0);
            k++;
        end
        start = 1'b0; wr_en = 1'b0; w_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, ":done_count"}, 64'(done_cnt - d0), 64'(1));
        chk({tag, ":beat_count"}, 64'(got_q.size() - q0), 64'(n));
        for (int i = 0; i < n && (q0 + i) < got_q.size(); i++)
            chk($sformatf("%s:beat%0d", tag, i), 64'(got_q[q0 + i]), 64'(exp_q[i]));
        chk({tag, ":stall_stable"}, 64'(stall_viol - s0), 64'(0));
        if (n == 0) chk({tag, ":valid_never"}, 64'(valid_cnt - v0), 64'(0));
        if (mode == 0) begin
            if (n == 0) begin
                chk({tag, ":done_cycle"}, 64'(done_cyc), 64'(s_cyc));
                chk({tag, ":busy_with_done"}, 64'(busy_at_done), 64'(1));
                chk({tag, ":busy_cycles"}, 64'(busy_cnt - b0), 64'(1));
            end else begin
                if (got_q.size() - q0 == n) begin
                    chk({tag, ":first_beat_cycle"}, 64'(hs_q[q0]), 64'(s_cyc + 1));
                    chk({tag, ":last_beat_cycle"}, 64'(hs_q[q0 + n - 1]), 64'(s_cyc + n));
                end
                chk({tag, ":done_cycle"}, 64'(done_cyc), 64'(s_cyc + n + 1));
                chk({tag, ":busy_at_done"}, 64'(busy_at_done), 64'(0));
                chk({tag, ":busy_cycles"}, 64'(busy_cnt - b0), 64'(n + 1));
            end
        end
        if (w1_at >= 0) model_mem[w1_addr] = w1_data;
        if (w2_at >= 0) model_mem[w2_addr] = w2_data;
    endtask

    initial begin
        int d0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        base_addr = '0; burst_len = '0; w_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:done", 64'(done), 64'(0));
        chk("rst:w_valid", 64'(w_valid), 64'(0));
        chk("rst:w_last", 64'(w_last), 64'(0));
        chk("rst:w_data", 64'(w_data), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload word k = k + 0xA5000000.
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = 32'hA500_0000 + 32'(k);
            model_mem[k] = 32'hA500_0000 + 32'(k);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;

        run_burst("basic", 0, 4, 0, -1, 0, 32'd0, -1, 0, 32'd0, -1);
        run_burst("wrap", 62, 4, 0, -1, 0, 32'd0, -1, 0, 32'd0, -1);
        run_burst("bp", 30, 8, 1, -1, 0, 32'd0, -1, 0, 32'd0, 3);
        run_burst("len0", 7, 0, 0, -1, 0, 32'd0, -1, 0, 32'd0, -1);
        run_burst("cwr", 0, 16, 0, 7, 10, 32'hDEAD_BEEF, 12, 12, 32'h1234_5678, -1);
        for (int r = 0; r < 4; r++)
            run_burst($sformatf("rnd%0d", r), int'($urandom_range(0, 63)), int'($urandom_range(1, 70)),
                      2, -1, 0, 32'd0, -1, 0, 32'd0, -1);
        run_burst("clamp", 20, 100, 2, -1, 0, 32'd0, -1, 0, 32'd0, -1);

        // Asynchronous reset in the middle of a burst, away from a clock edge.
        d0 = done_cnt;
        start = 1'b1; base_addr = AW'(0); burst_len = LW'(16); w_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("arst:busy_before", 64'(busy), 64'(1));
        chk("arst:valid_before", 64'(w_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("arst:w_valid", 64'(w_valid), 64'(0));
        chk("arst:busy", 64'(busy), 64'(0));
        chk("arst:done", 64'(done), 64'(0));
        chk("arst:w_data", 64'(w_data), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst:no_done", 64'(done_cnt - d0), 64'(0));
        chk("arst:idle_busy", 64'(busy), 64'(0));
        run_burst("post_rst", 0, 16, 0, -1, 0, 32'd0, -1, 0, 32'd0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
